// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between IF fetch and EX/MEM data access.
// Define ARB_RR_EN for round-robin arbitration; default is data-first.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ok,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ok,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_for_mem
);

  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q;
  logic                grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [SW-1:0]       wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   inst_rdata_q;
  logic [DATA_W-1:0]   data_rdata_q;
  logic                mem_req_q;
  logic                inst_ok_q;
  logic                data_ok_q;

  logic                grant_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                wr_d;
  logic [SW-1:0]       wstrb_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                cap;

`ifdef ARB_RR_EN
  logic                last_grant_q;

  // grant bit: 1 = data, 0 = inst
  assign grant_d = data_req & (~inst_req | ~last_grant_q);
`else
  assign grant_d = data_req;
`endif

  always_comb begin
    addr_d  = inst_addr;
    wr_d    = 1'b0;
    wstrb_d = '0;
    wdata_d = '0;
    if (grant_d) begin
      addr_d  = data_addr;
      wr_d    = data_wr;
      wstrb_d = data_wstrb;
      wdata_d = data_wdata;
    end
  end

  assign cap = ((state_q == S_REQ) & mem_addr_ok & mem_data_ok)
             | ((state_q == S_WAIT) & mem_data_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      mem_req_q <= 1'b0;
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (inst_req | data_req) begin
            state_q   <= S_REQ;
            mem_req_q <= 1'b1;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
          end
        end
        S_REQ: begin
          if (mem_addr_ok) begin
            mem_req_q <= 1'b0;
            if (mem_data_ok) begin
              state_q   <= S_DONE;
              inst_ok_q <= ~grant_q;
              data_ok_q <= grant_q;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_data_ok) begin
            state_q   <= S_DONE;
            inst_ok_q <= ~grant_q;
            data_ok_q <= grant_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
`ifdef ARB_RR_EN
          last_grant_q <= grant_q;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else if (cap) begin
      if (grant_q) data_rdata_q <= mem_rdata;
      else         inst_rdata_q <= mem_rdata;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_wr     = wr_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign inst_ok    = inst_ok_q;
  assign data_ok    = data_ok_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  // gated by reset so every output reads 0 while rst is low
  assign stallreq_for_mem = rst & ((inst_req & ~inst_ok_q)
                                 | (data_req & ~data_ok_q));

endmodule
